fp_normalize_pipe: RTL and testbench

//   Post-add normalization stage of the floating point adder: consumes the raw sum mantissa, the

---
 rtl/fp_normalize_pipe.sv | 140 ++++++++++++++
 tb/tb_fp_normalize_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fp_normalize_pipe.sv
// fp_normalize_pipe: two-stage post-add normalizer (stage A decides shift/exponent, stage B shifts).
// Optional build macro NORM_LZC_CHECK_EN adds a sticky recount check of the incoming LZC value.
module fp_normalize_pipe #(
    parameter int MANT_W = 28,
    parameter int CNT_W  = 5,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [CNT_W-1:0]  in_lzc,
    input  logic              in_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_zero,
    output logic              out_denorm,
    output logic              lzc_err
);
    localparam int CW = (EXP_W > CNT_W) ? EXP_W : CNT_W;

    logic              r_a_valid;
    logic              r_a_sign;
    logic              r_a_zero;
    logic              r_a_denorm;
    logic [EXP_W-1:0]  r_a_exp;
    logic [MANT_W-1:0] r_a_mant;
    logic [CNT_W-1:0]  r_a_sh;

    logic [CW-1:0]     w_lzc_x;
    logic [CW-1:0]     w_exp_x;
    logic [CNT_W-1:0]  w_sh;
    logic [EXP_W-1:0]  w_e;
    logic              w_dn;
    logic              w_b_free;
    logic              w_accept;
    logic [MANT_W-1:0] w_b_mant;

    assign w_b_free = !out_valid || out_ready;
    assign in_ready = !r_a_valid || w_b_free;
    assign w_accept = in_valid && in_ready;
    assign w_b_mant = r_a_zero ? '0 : (r_a_mant << r_a_sh);

    // Choose shift and exponent; clamp to a denormal instead of letting the exponent go below 1.
    always_comb begin
        w_lzc_x = CW'(in_lzc);
        w_exp_x = CW'(in_exp);
        w_sh    = '0;
        w_e     = '0;
        w_dn    = 1'b0;
        if (in_zero) begin
            w_dn = 1'b0;
        end else if (w_lzc_x < w_exp_x) begin
            w_sh = in_lzc;
            w_e  = EXP_W'(w_exp_x - w_lzc_x);
        end else if (in_exp != '0) begin
            w_sh = CNT_W'(w_exp_x - CW'(1));
            w_dn = 1'b1;
        end else begin
            w_dn = 1'b1;
        end
    end

    // Stage A: capture the beat together with its shift decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid  <= 1'b0;
            r_a_sign   <= 1'b0;
            r_a_zero   <= 1'b0;
            r_a_denorm <= 1'b0;
            r_a_exp    <= '0;
            r_a_mant   <= '0;
            r_a_sh     <= '0;
        end else if (in_ready) begin
            r_a_valid <= in_valid;
            if (in_valid) begin
                r_a_sign   <= in_sign;
                r_a_zero   <= in_zero;
                r_a_denorm <= w_dn;
                r_a_exp    <= w_e;
                r_a_mant   <= in_mant;
                r_a_sh     <= w_sh;
            end
        end
    end

    // Stage B: apply the shift; outputs hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sign   <= 1'b0;
            out_exp    <= '0;
            out_mant   <= '0;
            out_zero   <= 1'b0;
            out_denorm <= 1'b0;
        end else if (w_b_free) begin
            out_valid <= r_a_valid;
            if (r_a_valid) begin
                out_sign   <= r_a_sign;
                out_exp    <= r_a_exp;
                out_mant   <= w_b_mant;
                out_zero   <= r_a_zero;
                out_denorm <= r_a_denorm;
            end
        end
    end

`ifdef NORM_LZC_CHECK_EN
    logic [CNT_W-1:0] w_recount;
    logic             w_found;
    logic             w_bad;

    // Independent leading-zero recount of the incoming mantissa.
    always_comb begin
        w_recount = '0;
        w_found   = 1'b0;
        for (int i = MANT_W - 1; i >= 0; i--) begin
            if (in_mant[i]) w_found = 1'b1;
            else if (!w_found) w_recount = w_recount + 1'b1;
        end
        w_bad = (in_zero != (in_mant == '0)) || (!in_zero && (w_recount != in_lzc));
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lzc_err <= 1'b0;
        else if (w_accept && w_bad) lzc_err <= 1'b1;
    end
`else
    logic w_unused;
    assign w_unused = w_accept;
    assign lzc_err  = 1'b0;
`endif
endmodule

// File: tb/tb_fp_normalize_pipe.sv
// tb_fp_normalize_pipe: scoreboard bench for the normalization pipeline.
module tb_fp_normalize_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [27:0] in_mant = '0;
    logic [4:0]  in_lzc = '0;
    logic        in_zero = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [27:0] out_mant;
    logic        out_zero;
    logic        out_denorm;
    logic        lzc_err;

    fp_normalize_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_exp(in_exp),
        .in_mant(in_mant), .in_lzc(in_lzc), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
        .out_mant(out_mant), .out_zero(out_zero), .out_denorm(out_denorm), .lzc_err(lzc_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic s; logic [7:0] e; logic [27:0] m; logic [4:0] l; logic z;} vin_t;
    typedef struct packed {logic s; logic [7:0] e; logic [27:0] m; logic z; logic d;} vout_t;

    vin_t  vi[8];
    vout_t vo[8];
    vout_t q[$];
    int    total = 0;
    int    bad = 0;
    int    occ = 0;
    logic  held_v = 1'b0;
    vout_t held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    // Present one beat, wait for acceptance, record the expected result.
    task automatic send(input vin_t v, input vout_t r);
        logic acc;
        int   n;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_sign  = v.s;
        in_exp   = v.e;
        in_mant  = v.m;
        in_lzc   = v.l;
        in_zero  = v.z;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            n++;
            if (!acc && n > 50) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        if (acc) q.push_back(r);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: ready rule, hold-while-stalled, and in-order scoreboard compare.
    initial begin
        vout_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                occ = 0;
                held_v = 1'b0;
            end else begin
                chk("in_ready", {31'd0, in_ready}, {31'd0, (occ < 2) || out_ready});
                if (held_v) begin
                    chk("hold_valid", {31'd0, out_valid}, 32'd1);
                    chk("hold_mant", {4'd0, out_mant}, {4'd0, held.m});
                    chk("hold_exp", {24'd0, out_exp}, {24'd0, held.e});
                end
                held_v = out_valid && !out_ready;
                held = '{out_sign, out_exp, out_mant, out_zero, out_denorm};
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        r = q.pop_front();
                        chk("mant", {4'd0, out_mant}, {4'd0, r.m});
                        chk("exp", {24'd0, out_exp}, {24'd0, r.e});
                        chk("sign", {31'd0, out_sign}, {31'd0, r.s});
                        chk("zero", {31'd0, out_zero}, {31'd0, r.z});
                        chk("denorm", {31'd0, out_denorm}, {31'd0, r.d});
                    end
                end
                occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
            end
        end
    end

    initial begin
        logic want_err;
`ifdef NORM_LZC_CHECK_EN
        want_err = 1'b1;
`else
        want_err = 1'b0;
`endif
        vi[0] = '{1'b0, 8'd20,  28'h0040000, 5'd9,  1'b0}; vo[0] = '{1'b0, 8'd11,  28'h8000000, 1'b0, 1'b0};
        vi[1] = '{1'b0, 8'd5,   28'h0000100, 5'd19, 1'b0}; vo[1] = '{1'b0, 8'd0,   28'h0001000, 1'b0, 1'b1};
        vi[2] = '{1'b1, 8'd100, 28'h0000000, 5'd31, 1'b1}; vo[2] = '{1'b1, 8'd0,   28'h0000000, 1'b1, 1'b0};
        vi[3] = '{1'b0, 8'd0,   28'h1234567, 5'd3,  1'b0}; vo[3] = '{1'b0, 8'd0,   28'h1234567, 1'b0, 1'b1};
        vi[4] = '{1'b1, 8'd16,  28'h0000F00, 5'd16, 1'b0}; vo[4] = '{1'b1, 8'd0,   28'h7800000, 1'b0, 1'b1};
        vi[5] = '{1'b0, 8'd1,   28'h8000001, 5'd0,  1'b0}; vo[5] = '{1'b0, 8'd1,   28'h8000001, 1'b0, 1'b0};
        vi[6] = '{1'b0, 8'd27,  28'h0000003, 5'd26, 1'b0}; vo[6] = '{1'b0, 8'd1,   28'hC000000, 1'b0, 1'b0};
        vi[7] = '{1'b1, 8'd255, 28'h0FFFFFF, 5'd4,  1'b0}; vo[7] = '{1'b1, 8'd251, 28'hFFFFFF0, 1'b0, 1'b0};

        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_mant", {4'd0, out_mant}, 32'd0);
        chk("rst_out_exp", {24'd0, out_exp}, 32'd0);
        chk("rst_lzc_err", {31'd0, lzc_err}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 3; i++) begin
            send(vi[i], vo[i]);
            drain();
        end

        fork
            for (int i = 0; i < 8; i++) send(vi[i], vo[i]);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        send(vi[0], vo[0]);
        send(vi[5], vo[5]);
        @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_mant", {4'd0, out_mant}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(vi[7], vo[7]);
        drain();
        chk("pre_err", {31'd0, lzc_err}, 32'd0);

        send('{1'b0, 8'd50, 28'h0800000, 5'd3, 1'b0}, '{1'b0, 8'd47, 28'h4000000, 1'b0, 1'b0});
        #1 chk("lzc_err_set", {31'd0, lzc_err}, {31'd0, want_err});
        send(vi[6], vo[6]);
        drain();
        chk("lzc_err_sticky", {31'd0, lzc_err}, {31'd0, want_err});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
